// File: rtl/flag_uart_tx.sv
// Buffers decoded flag bytes in a 4-entry FIFO and serializes them as 8N1 UART frames.
// Byte to tx-low latency is two edges from an empty/idle state; in_ready drops while the FIFO is full.
module flag_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic [2:0] fifo_count
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [7:0]    mem_q [4];
  logic [7:0]    mem_d [4];
  logic [1:0]    wr_q, wr_d;
  logic [1:0]    rd_q, rd_d;
  logic [2:0]    count_q, count_d;
  logic          push, pop, baud_done;

  // No bypass: a full FIFO refuses input even on a cycle where the serializer pops.
  assign in_ready   = (count_q < 3'(FIFO_DEPTH)) && !rst;
  assign push       = in_valid && in_ready;
  assign baud_done  = (baud_q == BAUD_LAST);
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_q];
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit when another byte is waiting.
          if (count_q != 3'd0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = in_data;
      wr_d        = wr_q + 2'd1;
    end
    if (pop) begin
      rd_d = rd_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      wr_q    <= 2'd0;
      rd_q    <= 2'd0;
      count_q <= 3'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_flag_uart_tx.sv
// Scoreboard bench for flag_uart_tx at 4 clocks per bit: accepted bytes queue up,
// a line monitor rebuilds each 40-cycle frame and compares it with the queue head.
module tb_flag_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  flag_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Line monitor: collects 40 samples per frame, abandons a frame on reset.
  logic samp [40];
  int   mon_cnt = 0;
  bit   mon_active = 0;

  task automatic check_frame();
    logic [7:0] b;
    logic       ok;
    ok = 1'b1;
    for (int i = 0; i < CPB; i++) begin
      if (samp[i] !== 1'b0) ok = 1'b0;
      if (samp[36 + i] !== 1'b1) ok = 1'b0;
    end
    for (int j = 0; j < 8; j++) begin
      b[j] = samp[4 + 4 * j];
      for (int i = 1; i < CPB; i++)
        if (samp[4 + 4 * j + i] !== b[j]) ok = 1'b0;
    end
    chk("frame_format", {31'd0, ok}, 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL frame_unexpected: got %0h, expected no frame", b);
    end else begin
      chk("frame_data", {24'd0, b}, {24'd0, exp_q.pop_front()});
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1;
        samp[0]    = tx;
        mon_cnt    = 1;
      end
    end else begin
      samp[mon_cnt] = tx;
      mon_cnt++;
      if (mon_cnt == 40) begin
        mon_active = 0;
        check_frame();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("push_timeout", {31'd0, n < 200}, 32'd1);
    tick();
    in_valid = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || fifo_count != 3'd0) && n < 2000) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, n < 2000}, 32'd1);
    tick();
  endtask

  task automatic count_busy(input string name, input int exp_cycles);
    int c;
    c = 1;
    while (busy && c < 500) begin
      tick();
      if (busy) c++;
    end
    chk(name, c, exp_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] fb [6];
  int   acc_edge [6];
  int   idx, cyc, lows;
  logic acc;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    tick();

    // Single byte: latency and 40-cycle busy window.
    push(8'h6C);
    chk("single_count_after_push", {29'd0, fifo_count}, 32'd1);
    chk("single_tx_before_start", {31'd0, tx}, 32'd1);
    tick();
    chk("single_tx_start", {31'd0, tx}, 32'd0);
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk("single_count_after_pop", {29'd0, fifo_count}, 32'd0);
    count_busy("single_busy_cycles", 40);
    wait_idle();

    // Fill: six bytes offered continuously.
    fb = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5};
    for (int i = 0; i < 6; i++) acc_edge[i] = 0;
    idx = 0;
    cyc = 0;
    in_valid = 1'b1;
    in_data  = fb[0];
    while (idx < 6 && cyc < 400) begin
      acc = in_ready;
      tick();
      cyc++;
      if (acc) begin
        exp_q.push_back(fb[idx]);
        acc_edge[idx] = cyc;
        idx++;
        if (idx < 6) in_data = fb[idx];
      end
      if (cyc == 5) begin
        chk("fill_count_full", {29'd0, fifo_count}, 32'd4);
        chk("fill_ready_low", {31'd0, in_ready}, 32'd0);
      end
      if (cyc == 42) chk("fill_count_after_pop", {29'd0, fifo_count}, 32'd3);
    end
    in_valid = 1'b0;
    chk("fill_edge_a", acc_edge[0], 1);
    chk("fill_edge_e", acc_edge[4], 5);
    chk("fill_edge_f", acc_edge[5], 43);
    wait_idle();

    // Back-to-back frames with no idle gap.
    push(8'h41);
    push(8'h42);
    chk("b2b_busy_now", {31'd0, busy}, 32'd1);
    count_busy("b2b_busy_cycles", 80);
    wait_idle();

    // Push on the same edge as the idle pop from a count of one.
    in_data  = 8'h5A;
    in_valid = 1'b1;
    tick();
    exp_q.push_back(8'h5A);
    in_data = 8'h3C;
    tick();
    exp_q.push_back(8'h3C);
    in_valid = 1'b0;
    chk("simul_count", {29'd0, fifo_count}, 32'd1);
    chk("simul_busy", {31'd0, busy}, 32'd1);
    wait_idle();

    // Bit order.
    push(8'h80);
    push(8'h01);
    wait_idle();

    // Reset during DATA bit 3 with two bytes still queued.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (16) tick();
    chk("mid_count", {29'd0, fifo_count}, 32'd2);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_ready_after_rst", {31'd0, in_ready}, 32'd1);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("mid_no_more_frames", lows, 0);

    chk("all_frames_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
